// File: rtl/jtag_tap_multi.sv
// jtag_tap_multi: IEEE 1149.1 TAP controller with an instruction register,
// IDCODE and BYPASS data registers, and NUM_USER user data-register channels.
//
// Ports:
//   tck                - test clock, all state updates on its rising edge
//   trstn              - synchronous active-low reset
//   tms, tdi           - test mode select / test data in, sampled on rising tck
//   tdo, tdo_en        - serial data out (combinational) and its valid flag
//   ir_out             - currently latched instruction
//   user_capture_data  - per-channel capture values, channel k at [k*DR_WIDTH +: DR_WIDTH]
//   user_update_data   - per-channel update values, same packing
//   user_update_valid  - per-channel one-cycle pulse following Update-DR
module jtag_tap_multi #(
  parameter int unsigned IR_WIDTH = 4,
  parameter int unsigned DR_WIDTH = 32,
  parameter int unsigned NUM_USER = 2,
  parameter logic [31:0] IDCODE   = 32'h1000_0001
) (
  input  logic                         tck,
  input  logic                         trstn,
  input  logic                         tms,
  input  logic                         tdi,
  output logic                         tdo,
  output logic                         tdo_en,
  output logic [IR_WIDTH-1:0]          ir_out,
  input  logic [NUM_USER*DR_WIDTH-1:0] user_capture_data,
  output logic [NUM_USER*DR_WIDTH-1:0] user_update_data,
  output logic [NUM_USER-1:0]          user_update_valid
);

  localparam logic [31:0] IDCODE_VAL = IDCODE | 32'd1;

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
  } tap_state_t;

  tap_state_t state, next_state;

  logic [IR_WIDTH-1:0] ir_sr;
  logic [IR_WIDTH-1:0] ir_reg;
  logic [31:0]         idcode_sr;
  logic                bypass_sr;
  logic [DR_WIDTH-1:0] user_sr  [NUM_USER];
  logic [DR_WIDTH-1:0] upd_reg  [NUM_USER];
  logic [NUM_USER-1:0] valid_reg;
  logic                sel_idcode;
  logic [NUM_USER-1:0] sel_user;

  // State register
  always_ff @(posedge tck) begin
    if (!trstn) state <= TLR;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      TLR:      next_state = tms ? TLR      : RTI;
      RTI:      next_state = tms ? SEL_DR   : RTI;
      SEL_DR:   next_state = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   next_state = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: next_state = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: next_state = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: next_state = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: next_state = tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   next_state = tms ? SEL_DR   : RTI;
      SEL_IR:   next_state = tms ? TLR      : CAP_IR;
      CAP_IR:   next_state = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: next_state = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: next_state = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: next_state = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: next_state = tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   next_state = tms ? SEL_DR   : RTI;
      default:  next_state = TLR;
    endcase
  end

  // Instruction decode; unmapped codes fall through to BYPASS
  always_comb begin
    sel_idcode = (ir_reg == IR_WIDTH'(1));
    sel_user   = '0;
    for (int unsigned k = 0; k < NUM_USER; k++)
      sel_user[k] = (ir_reg == IR_WIDTH'(k + 2));
  end

  // Instruction and data register datapath
  always_ff @(posedge tck) begin
    if (!trstn) begin
      ir_sr     <= '0;
      ir_reg    <= IR_WIDTH'(1);
      idcode_sr <= '0;
      bypass_sr <= 1'b0;
      valid_reg <= '0;
      for (int unsigned k = 0; k < NUM_USER; k++) begin
        user_sr[k] <= '0;
        upd_reg[k] <= '0;
      end
    end else begin
      // Loaded on the edge entering TLR so ir_out reads IDCODE throughout TLR
      if (next_state == TLR)   ir_reg <= IR_WIDTH'(1);
      else if (state == UPD_IR) ir_reg <= ir_sr;

      if (state == CAP_IR)        ir_sr <= IR_WIDTH'(1);
      else if (state == SHIFT_IR) ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};

      if (sel_idcode) begin
        if (state == CAP_DR)        idcode_sr <= IDCODE_VAL;
        else if (state == SHIFT_DR) idcode_sr <= {tdi, idcode_sr[31:1]};
      end

      if (!sel_idcode && sel_user == '0) begin
        if (state == CAP_DR)        bypass_sr <= 1'b0;
        else if (state == SHIFT_DR) bypass_sr <= tdi;
      end

      valid_reg <= '0;
      for (int unsigned k = 0; k < NUM_USER; k++) begin
        if (sel_user[k]) begin
          if (state == CAP_DR)
            user_sr[k] <= user_capture_data[k*DR_WIDTH +: DR_WIDTH];
          else if (state == SHIFT_DR)
            // Widened before shifting so DR_WIDTH = 1 needs no special case
            user_sr[k] <= DR_WIDTH'({tdi, user_sr[k]} >> 1);
          if (state == UPD_DR) begin
            upd_reg[k]   <= user_sr[k];
            valid_reg[k] <= 1'b1;
          end
        end
      end
    end
  end

  // Serial output mux
  always_comb begin
    tdo    = 1'b0;
    tdo_en = 1'b0;
    if (state == SHIFT_IR) begin
      tdo_en = 1'b1;
      tdo    = ir_sr[0];
    end else if (state == SHIFT_DR) begin
      tdo_en = 1'b1;
      tdo    = sel_idcode ? idcode_sr[0] : bypass_sr;
      for (int unsigned k = 0; k < NUM_USER; k++)
        if (sel_user[k]) tdo = user_sr[k][0];
    end
  end

  for (genvar g = 0; g < NUM_USER; g++) begin : g_pack
    assign user_update_data[g*DR_WIDTH +: DR_WIDTH] = upd_reg[g];
  end

  assign ir_out            = ir_reg;
  assign user_update_valid = valid_reg;

endmodule

// File: tb/tb_jtag_tap_multi.sv
// tb_jtag_tap_multi: directed bench for jtag_tap_multi with default parameters.
module tb_jtag_tap_multi;

  logic        tck = 1'b0;
  logic        trstn;
  logic        tms;
  logic        tdi;
  logic        tdo;
  logic        tdo_en;
  logic [3:0]  ir_out;
  logic [63:0] user_capture_data;
  logic [63:0] user_update_data;
  logic [1:0]  user_update_valid;

  int tests = 0;
  int fails = 0;

  logic [63:0] dout;
  logic [7:0]  irout;

  jtag_tap_multi #(
    .IR_WIDTH(4),
    .DR_WIDTH(32),
    .NUM_USER(2),
    .IDCODE(32'h1000_0001)
  ) dut (
    .tck(tck),
    .trstn(trstn),
    .tms(tms),
    .tdi(tdi),
    .tdo(tdo),
    .tdo_en(tdo_en),
    .ir_out(ir_out),
    .user_capture_data(user_capture_data),
    .user_update_data(user_update_data),
    .user_update_valid(user_update_valid)
  );

  always #5 tck = ~tck;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply tms/tdi, take one rising edge, then settle 1 time unit
  task automatic step(input logic t, input logic d);
    tms = t;
    tdi = d;
    @(posedge tck);
    #1;
  endtask

  // From Run-Test/Idle: scan n DR bits, pass Update-DR, end in Run-Test/Idle
  task automatic shift_dr(input logic [63:0] din, input int n, output logic [63:0] dq);
    dq = '0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      dq[i] = tdo;
      step(i == n - 1, din[i]);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // From Run-Test/Idle: scan a 4-bit instruction, end in Run-Test/Idle
  task automatic shift_ir(input logic [3:0] v, output logic [7:0] iq);
    iq = '0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      iq[i] = tdo;
      step(i == 3, v[i]);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    trstn = 1'b0;
    tms = 1'b1;
    tdi = 1'b0;
    user_capture_data = '0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("rst_ir_out", 64'(ir_out), 64'h1);
    check("rst_tdo", 64'(tdo), 64'h0);
    check("rst_tdo_en", 64'(tdo_en), 64'h0);
    check("rst_upd_data", user_update_data, 64'h0);
    check("rst_upd_valid", 64'(user_update_valid), 64'h0);

    trstn = 1'b1;
    step(1'b0, 1'b0);
    check("rti_ir_out", 64'(ir_out), 64'h1);

    // IDCODE selected by default
    shift_dr(64'h0, 32, dout);
    check("idcode_tdo", dout, 64'h1000_0001);
    check("idcode_no_valid", 64'(user_update_valid), 64'h0);

    // IR capture pattern and BYPASS instruction
    shift_ir(4'hF, irout);
    check("ir_capture_tdo", 64'(irout), 64'h1);
    check("ir_out_F", 64'(ir_out), 64'hF);
    shift_dr(64'h1_5555_5555, 33, dout);
    check("bypass_F_tdo", dout, 64'h0_AAAA_AAAA);
    check("bypass_no_valid", 64'(user_update_valid), 64'h0);

    // USER_0
    user_capture_data = {32'hCAFE_F00D, 32'hDEAD_BEEF};
    shift_ir(4'h2, irout);
    check("ir_out_2", 64'(ir_out), 64'h2);
    shift_dr(64'h1234_5678, 32, dout);
    check("user0_tdo", dout, 64'hDEAD_BEEF);
    check("user0_valid", 64'(user_update_valid), 64'h1);
    check("user0_upd", user_update_data, 64'h0000_0000_1234_5678);
    step(1'b0, 1'b0);
    check("user0_valid_drop", 64'(user_update_valid), 64'h0);

    // USER_1, channel 0 holds
    shift_ir(4'h3, irout);
    shift_dr(64'hA5A5_0F0F, 32, dout);
    check("user1_tdo", dout, 64'hCAFE_F00D);
    check("user1_valid", 64'(user_update_valid), 64'h2);
    check("user1_upd", user_update_data, 64'hA5A5_0F0F_1234_5678);

    // Zero-length shift; capture input changed after Capture-DR is ignored
    user_capture_data = {32'h1111_2222, 32'hDEAD_BEEF};
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    user_capture_data = {32'h3333_4444, 32'hDEAD_BEEF};
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("zero_len_valid", 64'(user_update_valid), 64'h2);
    check("zero_len_upd", user_update_data, 64'h1111_2222_1234_5678);

    // Unmapped code behaves as BYPASS
    shift_ir(4'h9, irout);
    check("ir_out_9", 64'(ir_out), 64'h9);
    shift_dr(64'hB2, 8, dout);
    check("bypass_9_tdo", dout, 64'h64);
    check("bypass_9_no_valid", 64'(user_update_valid), 64'h0);

    // Reset in the middle of a USER_1 shift
    shift_ir(4'h3, irout);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("shift_tdo_en", 64'(tdo_en), 64'h1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    trstn = 1'b0;
    step(1'b0, 1'b0);
    check("midrst_tdo_en", 64'(tdo_en), 64'h0);
    check("midrst_ir_out", 64'(ir_out), 64'h1);
    check("midrst_valid", 64'(user_update_valid), 64'h0);
    check("midrst_upd", user_update_data, 64'h0);
    trstn = 1'b1;
    step(1'b0, 1'b0);
    check("postrst_valid", 64'(user_update_valid), 64'h0);
    shift_dr(64'h0, 32, dout);
    check("postrst_idcode", dout, 64'h1000_0001);

    // TMS reset from Pause-DR keeps user_update_data
    shift_ir(4'h2, irout);
    user_capture_data = {32'h3333_4444, 32'h0BAD_F00D};
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("tms_rst_ir_out", 64'(ir_out), 64'h1);
    check("tms_rst_upd", user_update_data, 64'h0000_0000_0BAD_F00D);
    check("tms_rst_valid", 64'(user_update_valid), 64'h0);
    step(1'b0, 1'b0);
    shift_dr(64'h0, 32, dout);
    check("tms_rst_idcode", dout, 64'h1000_0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
